// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
package reg_file_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 3;

  // Soft-clear controller states: StIdle is IDLE, StSweep is SWEEP.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_rdport.sv
// One registered read port with write-first bypass.
// Optional feature macro: ZERO_REG_EN (address 0 always reads as zero, no bypass).
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    rd_en_i,
  input  logic [ADDR_W-1:0]                       rd_addr_i,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]      regs_i,
  input  logic                                    wr_en_i,
  input  logic [ADDR_W-1:0]                       wr_addr_i,
  input  logic [DATA_W-1:0]                       wr_data_i,
  output logic [DATA_W-1:0]                       rd_data_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              addr_is_zero;

  assign addr_is_zero = (rd_addr_i == '0);

  // Next read data: hold unless a read is accepted; an accepted same-edge write wins.
  always_comb begin
    data_d = data_q;
    if (rd_en_i) begin
`ifdef ZERO_REG_EN
      if (addr_is_zero) begin
        data_d = '0;
      end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        data_d = wr_data_i;
      end else begin
        data_d = regs_i[rd_addr_i];
      end
`else
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        data_d = wr_data_i;
      end else begin
        data_d = regs_i[rd_addr_i];
      end
`endif
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;

`ifndef ZERO_REG_EN
  // Only consulted when register 0 is hardwired.
  logic unused_addr_is_zero;
  assign unused_addr_is_zero = addr_is_zero;
`endif

endmodule

// File: rtl/reg_file_param.sv
// DEPTH x DATA_W register file: one write port, two registered read ports with
// write-first bypass, read-valid strobe and a sequential soft-clear sweep.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INaddr,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1addr,
  input  logic [ADDR_W-1:0] OUT2addr,
  input  logic              READ,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT_VALID,
  input  logic              CLEAR,
  output logic              BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            ptr_q, ptr_d;
  logic                         valid_q, valid_d;

  logic idle;
  logic clear_acc;
  logic wr_acc;
  logic rd_acc;

  assign idle      = (state_q == StIdle);
  assign clear_acc = idle && CLEAR;
  assign rd_acc    = idle && READ;

  // A write is dropped while sweeping and on the edge that starts a sweep.
  always_comb begin
    wr_acc = idle && WRITE && !CLEAR;
`ifdef ZERO_REG_EN
    if (INaddr == '0) begin
      wr_acc = 1'b0;
    end
`endif
  end

  // Clear controller: next state and sweep pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (CLEAR) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        if (ptr_q == LastAddr) begin
          // Terminate on the last entry rather than wrapping.
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  // Array next state: sweep clears one entry per edge, otherwise accepted writes land.
  always_comb begin
    regs_d = regs_q;
    if (state_q == StSweep) begin
      regs_d[ptr_q] = '0;
    end else if (wr_acc) begin
      regs_d[INaddr] = IN;
    end
  end

  // Valid strobe follows each accepted read for exactly one cycle.
  always_comb begin
    valid_d = rd_acc;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      regs_q  <= '0;
      state_q <= StIdle;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  reg_file_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport1 (
    .clk_i     (clk),
    .rst_i     (RESET),
    .rd_en_i   (rd_acc),
    .rd_addr_i (OUT1addr),
    .regs_i    (regs_q),
    .wr_en_i   (wr_acc),
    .wr_addr_i (INaddr),
    .wr_data_i (IN),
    .rd_data_o (OUT1)
  );

  reg_file_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport2 (
    .clk_i     (clk),
    .rst_i     (RESET),
    .rd_en_i   (rd_acc),
    .rd_addr_i (OUT2addr),
    .regs_i    (regs_q),
    .wr_en_i   (wr_acc),
    .wr_addr_i (INaddr),
    .wr_data_i (IN),
    .rd_data_o (OUT2)
  );

  assign OUT_VALID = valid_q;
  assign BUSY      = (state_q == StSweep);

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: a driver applies directed and random
// operations, updates a behavioural model and queues the expected outputs;
// a monitor checks the DUT against the queue every cycle.
// Honours ZERO_REG_EN the same way as the design.
module tb_reg_file_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          RESET = 1'b0;
  logic [DW-1:0] IN = '0;
  logic [AW-1:0] INaddr = '0;
  logic          WRITE = 1'b0;
  logic [AW-1:0] OUT1addr = '0;
  logic [AW-1:0] OUT2addr = '0;
  logic          READ = 1'b0;
  logic [DW-1:0] OUT1;
  logic [DW-1:0] OUT2;
  logic          OUT_VALID;
  logic          CLEAR = 1'b0;
  logic          BUSY;

  reg_file_param #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .IN        (IN),
    .INaddr    (INaddr),
    .WRITE     (WRITE),
    .OUT1addr  (OUT1addr),
    .OUT2addr  (OUT2addr),
    .READ      (READ),
    .OUT1      (OUT1),
    .OUT2      (OUT2),
    .OUT_VALID (OUT_VALID),
    .CLEAR     (CLEAR),
    .BUSY      (BUSY)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit [DW-1:0] o1;
    bit [DW-1:0] o2;
    bit          busy;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model: contents, last read data and remaining sweep cycles.
  bit [DW-1:0] m_mem[DEPTH];
  bit [DW-1:0] m_o1, m_o2;
  bit          m_valid;
  int          m_busy_left;
  int          m_sweep_idx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit [DW-1:0] model_read(input bit [AW-1:0] a, input bit wacc,
                                             input bit [AW-1:0] wa, input bit [DW-1:0] wd);
`ifdef ZERO_REG_EN
    if (a == 0) return '0;
`endif
    if (wacc && a == wa) return wd;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_o1        = '0;
    m_o2        = '0;
    m_valid     = 1'b0;
    m_busy_left = 0;
    m_sweep_idx = 0;
  endtask

  // Apply one cycle of stimulus, advance the model, queue the expected result.
  task automatic step(input bit wr, input bit [AW-1:0] wa, input bit [DW-1:0] wd,
                      input bit rd, input bit [AW-1:0] a1, input bit [AW-1:0] a2,
                      input bit clr);
    bit   wacc;
    exp_t e;
    WRITE    = wr;
    INaddr   = wa;
    IN       = wd;
    READ     = rd;
    OUT1addr = a1;
    OUT2addr = a2;
    CLEAR    = clr;
    if (m_busy_left > 0) begin
      m_mem[m_sweep_idx] = '0;
      m_sweep_idx++;
      m_busy_left--;
      m_valid = 1'b0;
    end else begin
      wacc = wr && !clr;
`ifdef ZERO_REG_EN
      if (wa == 0) wacc = 1'b0;
`endif
      if (rd) begin
        m_o1    = model_read(a1, wacc, wa, wd);
        m_o2    = model_read(a2, wacc, wa, wd);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wacc) m_mem[wa] = wd;
      if (clr) begin
        m_busy_left = DEPTH;
        m_sweep_idx = 0;
      end
    end
    e.valid = m_valid;
    e.o1    = m_o1;
    e.o2    = m_o2;
    e.busy  = (m_busy_left != 0);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Assert reset mid-cycle, check the immediate effect, release before the next step.
  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    WRITE  = 1'b0;
    READ   = 1'b0;
    CLEAR  = 1'b0;
    RESET  = 1'b1;
    #1;
    check("rst_out1", 32'(OUT1), 32'h0);
    check("rst_out2", 32'(OUT2), 32'h0);
    check("rst_valid", 32'(OUT_VALID), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    @(negedge clk);
    #1;
    RESET = 1'b0;
    model_reset();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_empty: no expectation available at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("out_valid", 32'(OUT_VALID), 32'(e.valid));
          check("busy", 32'(BUSY), 32'(e.busy));
          check("out1", 32'(OUT1), 32'(e.o1));
          check("out2", 32'(OUT2), 32'(e.o2));
        end
      end
    end
  end

  initial begin
    model_reset();
    #2;
    RESET = 1'b1;
    #1;
    check("init_out1", 32'(OUT1), 32'h0);
    check("init_out2", 32'(OUT2), 32'h0);
    check("init_valid", 32'(OUT_VALID), 32'h0);
    check("init_busy", 32'(BUSY), 32'h0);
    @(negedge clk);
    #1;
    RESET  = 1'b0;
    mon_en = 1'b1;

    // Write then read with a one-cycle valid pulse, outputs holding afterwards.
    step(1'b1, 3'd5, 8'hB7, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 3'd5, 3'd0, 1'b0);
    idle_step();
    idle_step();

    // Same-edge write and read on both ports: bypass.
    step(1'b1, 3'd1, 8'h95, 1'b1, 3'd1, 3'd1, 1'b0);
    idle_step();

    // Fill everything, then clear alongside a write that must be dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), DW'($urandom_range(1, 255)), 1'b0, '0, '0, 1'b0);
    step(1'b1, 3'd2, 8'h3C, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom), AW'($urandom), 1'b1);
    end
    for (int i = 0; i < DEPTH; i += 2) step(1'b0, '0, '0, 1'b1, AW'(i), AW'(i + 1), 1'b0);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
           ($urandom_range(0, 15) == 0));
    end
    while (m_busy_left > 0) idle_step();

    // Asynchronous reset with nonzero contents, then every address reads zero.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), DW'(8'hA0 + i), 1'b0, '0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i += 2) step(1'b0, '0, '0, 1'b1, AW'(i), AW'(i + 1), 1'b0);
    idle_step();

    // Reset part-way through a sweep, then a normal write and read.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), DW'(8'h11 * (i + 1)), 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle_step();
    idle_step();
    do_reset();
    step(1'b1, 3'd3, 8'h5A, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 3'd3, 3'd0, 1'b0);
    idle_step();

    // Register 0: write with same-edge read, then a later read.
    step(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 3'd0, 3'd3, 1'b0);
    idle_step();

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
